rs_bank: RTL and testbench
==========================

// Module: rs_bank
// PURPOSE
//  Parametrised reservation-station bank: ENTRIES slots with one dispatch and one issue per cycle.
//  Each slot holds an opaque decoded payload, a destination ROB tag and two source operands (tag or value).
//  Wakes operands from CDB_PORTS broadcast buses and issues the oldest ready slot to its FU channel.
//  Sits between dispatch (decoder + map table + ROB read) and the execute stage.
//  Successor to the single-entry RS: adds depth, multi-CDB wakeup, age ordering, handshakes and occupancy.
// PARAMETERS
//  ENTRIES    8   number of RS slots (>=2)
//  CDB_PORTS  2   number of CDB broadcast ports (>=1)
//  TAG_W      5   ROB tag width
//  XLEN       32  operand width
//  PAYLOAD_W  64  opaque decoded-instruction payload width (carried unchanged)
//  BYPASS     1   1: a slot whose last operand is broadcast this cycle may issue this cycle
// PORTS
//  clock           in   1                    rising-edge clock
//  reset_n         in   1                    async active-low reset
//  squash          in   1                    sync flush of all slots
//  disp_valid      in   1                    dispatch request
//  disp_ready      out  1                    slot free (not full)
//  disp_payload    in   PAYLOAD_W            decoded instruction
//  disp_dest_tag   in   TAG_W                ROB tag of result
//  disp_rsN_rdy    in   1 (N=1,2)            operand N value is valid
//  disp_rsN_tag    in   TAG_W                producer tag if not ready
//  disp_rsN_value  in   XLEN                 operand value (regfile/ROB)
//  cdb_valid       in   CDB_PORTS            per-port broadcast valid
//  cdb_tag         in   CDB_PORTS*TAG_W      per-port tag (port p at [p*TAG_W +: TAG_W])
//  cdb_value       in   CDB_PORTS*XLEN       per-port value
//  issue_valid     out  1                    issue slot presented
//  issue_ready     in   1                    FU accepts
//  issue_payload   out  PAYLOAD_W            payload of selected slot
//  issue_dest_tag  out  TAG_W                dest tag of selected slot
//  issue_rs1_value out  XLEN                 resolved operand 1
//  issue_rs2_value out  XLEN                 resolved operand 2
//  free_count      out  $clog2(ENTRIES+1)    number of free slots
//  empty           out  1                    no busy slot
// BEHAVIOUR
//  Reset (reset_n low, async): all busy=0; all age bits=0; free_count=ENTRIES; empty=1; disp_ready=1; issue_valid=0.
//  Reset: issue_* data outputs are 0.
//  Squash (sync): next edge all busy=0 and age cleared; squash overrides dispatch, issue and wakeup.
//  Outputs are combinational from state while squash is high.
//  Dispatch: accepted when disp_valid && disp_ready.
//   - Writes the lowest-index slot free at the start of the cycle.
//   - A slot freed by issue in the same cycle is not reused until the next cycle.
//   - Latency: the entry is visible next cycle.
//  Dispatch operand capture, per source, in priority order:
//   1. rdy=1: take disp value.
//   2. Any cdb_valid[p] with cdb_tag[p]==rs_tag: capture cdb_value[p] as ready.
//   3. Otherwise store the tag as pending.
//  Wakeup: each busy pending operand compares against all CDB ports every cycle.
//   - On match: value latched, operand ready at the next edge.
//   - Multiple ports matching the same tag: lowest port wins (legal only if values are equal).
//  Ready (slot): busy and both operands ready. With BYPASS=1, a pending operand matched by a CDB this cycle also counts.
//   - In that case the issue value is muxed combinationally from the CDB.
//  Age: ENTRIES x ENTRIES matrix. On dispatch into slot i, row i = current busy vector (1 = slot is older than i).
//   - Issue selects the ready slot j such that no other ready k has age[j][k]=1.
//   - This is exactly one slot when any slot is ready.
//  Issue: issue_valid = any slot ready; outputs show the oldest ready slot.
//   - On issue_valid && issue_ready the slot is freed at the edge.
//   - On freeing, clear column j of every row.
//   - If issue_ready=0, outputs hold. Selection may change only if an older slot becomes ready.
//  Full: disp_ready=0 when free_count==0. A disp_valid while full is ignored and state is unchanged.
//  Same-cycle dispatch + issue while full: issue frees, dispatch is still refused.
//  free_count = ENTRIES - popcount(busy); empty = (free_count==ENTRIES); both registered-state derived.
//  Dispatching an instruction whose operand is already ready is legal. It issues at the earliest next cycle (no dispatch->issue bypass).
// STRUCTURE
//  Shared package (rs_pkg): rs_operand_t {rdy, tag, value}; rs_slot_t {busy, payload, dest_tag, op1, op2}.
//  Shared package (rs_pkg): function cdb_match(tag, cdb_valid, cdb_tag) -> {hit, port index}.
//  Sub-module rs_age_select: age matrix update plus oldest-ready one-hot select.
//  Sub-module rs_age_select: parametrised by ENTRIES; outputs grant one-hot and any_ready.
//  Top: slot registers in a generate loop, lowest-free priority encoder, operand muxes, popcount.
// TESTING
//  1. Reset with ENTRIES=8 -> free_count=8, empty=1, disp_ready=1, issue_valid=0, even while disp_valid=1 during reset.
//  2. Dispatch tags 3,4,5 all with ready operands, issue_ready=0 for 3 cycles, then 1.
//     -> issues dest tags 3,4,5 in order, one per cycle. After the last issue, empty=1.
//  3. Dispatch dest 7, rs1 pending on tag 9, rs2 ready value 0x10. Next cycle cdb port1 tag 9 value 0xAB, BYPASS=1.
//     -> issue_valid same cycle, rs1=0xAB, rs2=0x10.
//     -> With BYPASS=0, issue occurs one cycle later with the same values.
//  4. Dispatch rs1 pending on tag 2 while cdb port0 broadcasts tag 2 value 0x55 in the same cycle.
//     -> next cycle slot is ready, issue_rs1_value=0x55.
//  5. Fill 8 slots with pending operands -> disp_ready=0, a 9th dispatch is dropped.
//     -> Broadcast the tag of slot 5: it issues and free_count goes 0->1.
//     -> The next dispatch lands in slot 5.
//  6. Squash with 4 busy slots and a simultaneous dispatch -> next cycle empty=1, free_count=8.
//     -> Deasserting reset_n mid-issue clears issue_valid immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared operand/slot types and CDB lookup helpers for the reservation-station bank.
package rs_pkg;

  localparam int RS_TAG_W     = 5;
  localparam int RS_XLEN      = 32;
  localparam int RS_PAYLOAD_W = 64;
  localparam int RS_CDB_PORTS = 2;
  localparam int RS_PORT_W    = (RS_CDB_PORTS > 1) ? $clog2(RS_CDB_PORTS) : 1;

  typedef struct packed {
    logic                rdy;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  value;
  } rs_operand_t;

  typedef struct packed {
    logic                    busy;
    logic [RS_PAYLOAD_W-1:0] payload;
    logic [RS_TAG_W-1:0]     dest_tag;
    rs_operand_t             op1;
    rs_operand_t             op2;
  } rs_slot_t;

  typedef struct packed {
    logic                 hit;
    logic [RS_PORT_W-1:0] port;
  } rs_match_t;

  // Scan from the top so the lowest matching port is the one left standing.
  function automatic rs_match_t cdb_match(
    input logic [RS_TAG_W-1:0]              tag,
    input logic [RS_CDB_PORTS-1:0]          cdb_valid,
    input logic [RS_CDB_PORTS*RS_TAG_W-1:0] cdb_tag
  );
    rs_match_t m;
    m = '0;
    for (int p = RS_CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_tag[p*RS_TAG_W +: RS_TAG_W] == tag)) begin
        m.hit  = 1'b1;
        m.port = RS_PORT_W'(p);
      end
    end
    return m;
  endfunction

  function automatic logic [RS_XLEN-1:0] cdb_pick(
    input logic [RS_PORT_W-1:0]            port,
    input logic [RS_CDB_PORTS*RS_XLEN-1:0] cdb_value
  );
    logic [RS_XLEN-1:0] v;
    v = '0;
    for (int p = 0; p < RS_CDB_PORTS; p++) begin
      if (port == RS_PORT_W'(p)) begin
        v = cdb_value[p*RS_XLEN +: RS_XLEN];
      end
    end
    return v;
  endfunction

  function automatic rs_operand_t op_capture(
    input logic                             rdy,
    input logic [RS_TAG_W-1:0]              tag,
    input logic [RS_XLEN-1:0]               value,
    input logic [RS_CDB_PORTS-1:0]          cdb_valid,
    input logic [RS_CDB_PORTS*RS_TAG_W-1:0] cdb_tag,
    input logic [RS_CDB_PORTS*RS_XLEN-1:0]  cdb_value
  );
    rs_operand_t o;
    rs_match_t   m;
    m     = cdb_match(tag, cdb_valid, cdb_tag);
    o.tag = tag;
    if (rdy) begin
      o.rdy   = 1'b1;
      o.value = value;
    end else if (m.hit) begin
      o.rdy   = 1'b1;
      o.value = cdb_pick(m.port, cdb_value);
    end else begin
      o.rdy   = 1'b0;
      o.value = '0;
    end
    return o;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix (row i, bit k set = slot k is older than slot i) and oldest-ready one-hot grant.
module rs_age_select import rs_pkg::*; #(
  parameter int ENTRIES = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               squash,
  input  logic [ENTRIES-1:0] i_alloc_oh,
  input  logic [ENTRIES-1:0] i_busy,
  input  logic [ENTRIES-1:0] i_free_oh,
  input  logic [ENTRIES-1:0] i_ready,
  output logic [ENTRIES-1:0] o_grant,
  output logic               o_any_ready
);

  logic [ENTRIES-1:0] r_age [ENTRIES];

  // Freed slots drop out of every row so a later reuse starts as the youngest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) r_age[i] <= '0;
    end else if (squash) begin
      for (int i = 0; i < ENTRIES; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (i_alloc_oh[i]) r_age[i] <= i_busy & ~i_free_oh;
        else               r_age[i] <= r_age[i] & ~i_free_oh;
      end
    end
  end

  // A ready slot wins when no other ready slot is older than it.
  always_comb begin
    o_grant = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      o_grant[j] = i_ready[j] & ~(|(r_age[j] & i_ready));
    end
  end

  assign o_any_ready = |i_ready;

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: lowest-free dispatch, multi-port CDB wakeup, oldest-ready issue.
module rs_bank import rs_pkg::*; #(
  parameter int  ENTRIES   = 8,
  parameter int  CDB_PORTS = RS_CDB_PORTS,
  parameter int  TAG_W     = RS_TAG_W,
  parameter int  XLEN      = RS_XLEN,
  parameter int  PAYLOAD_W = RS_PAYLOAD_W,
  parameter bit  BYPASS    = 1'b1,
  localparam int FC_W      = $clog2(ENTRIES + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      squash,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [PAYLOAD_W-1:0]      disp_payload,
  input  logic [TAG_W-1:0]          disp_dest_tag,
  input  logic                      disp_rs1_rdy,
  input  logic [TAG_W-1:0]          disp_rs1_tag,
  input  logic [XLEN-1:0]           disp_rs1_value,
  input  logic                      disp_rs2_rdy,
  input  logic [TAG_W-1:0]          disp_rs2_tag,
  input  logic [XLEN-1:0]           disp_rs2_value,
  input  logic [CDB_PORTS-1:0]      cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0] cdb_value,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [PAYLOAD_W-1:0]      issue_payload,
  output logic [TAG_W-1:0]          issue_dest_tag,
  output logic [XLEN-1:0]           issue_rs1_value,
  output logic [XLEN-1:0]           issue_rs2_value,
  output logic [FC_W-1:0]           free_count,
  output logic                      empty
);

  logic [ENTRIES-1:0]   w_busy, w_ready, w_alloc_oh, w_grant, w_free_oh;
  logic                 w_any_ready, w_disp_fire, w_issue_fire;
  logic [PAYLOAD_W-1:0] w_payload [ENTRIES];
  logic [TAG_W-1:0]     w_dest    [ENTRIES];
  logic [XLEN-1:0]      w_val1    [ENTRIES];
  logic [XLEN-1:0]      w_val2    [ENTRIES];
  logic [FC_W-1:0]      w_busy_cnt;
  rs_slot_t             w_disp_slot;

  // Lowest clear bit of the start-of-cycle busy vector; zero when full.
  assign w_alloc_oh   = ~w_busy & (w_busy + {{(ENTRIES-1){1'b0}}, 1'b1});
  assign disp_ready   = ~(&w_busy);
  assign w_disp_fire  = disp_valid & disp_ready;
  assign w_issue_fire = w_any_ready & issue_ready;
  assign w_free_oh    = w_grant & {ENTRIES{w_issue_fire}};
  assign issue_valid  = w_any_ready;
  assign empty        = ~(|w_busy);
  assign free_count   = FC_W'(ENTRIES) - w_busy_cnt;

  // New entry image, operands resolved from the dispatch bus or a same-cycle broadcast.
  always_comb begin
    w_disp_slot          = '0;
    w_disp_slot.busy     = 1'b1;
    w_disp_slot.payload  = disp_payload;
    w_disp_slot.dest_tag = disp_dest_tag;
    w_disp_slot.op1 = op_capture(disp_rs1_rdy, disp_rs1_tag, disp_rs1_value,
                                 cdb_valid, cdb_tag, cdb_value);
    w_disp_slot.op2 = op_capture(disp_rs2_rdy, disp_rs2_tag, disp_rs2_value,
                                 cdb_valid, cdb_tag, cdb_value);
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
    rs_slot_t           r_slot;
    rs_match_t          w_m1, w_m2;
    logic               w_wake1, w_wake2, w_ok1, w_ok2;
    logic [XLEN-1:0]    w_cdb1, w_cdb2;

    assign w_m1    = cdb_match(r_slot.op1.tag, cdb_valid, cdb_tag);
    assign w_m2    = cdb_match(r_slot.op2.tag, cdb_valid, cdb_tag);
    assign w_cdb1  = cdb_pick(w_m1.port, cdb_value);
    assign w_cdb2  = cdb_pick(w_m2.port, cdb_value);
    assign w_wake1 = r_slot.busy & ~r_slot.op1.rdy & w_m1.hit;
    assign w_wake2 = r_slot.busy & ~r_slot.op2.rdy & w_m2.hit;
    assign w_ok1   = r_slot.op1.rdy | (BYPASS & w_wake1);
    assign w_ok2   = r_slot.op2.rdy | (BYPASS & w_wake2);

    assign w_busy[i]    = r_slot.busy;
    assign w_ready[i]   = r_slot.busy & w_ok1 & w_ok2;
    assign w_payload[i] = r_slot.payload;
    assign w_dest[i]    = r_slot.dest_tag;
    assign w_val1[i]    = r_slot.op1.rdy ? r_slot.op1.value : w_cdb1;
    assign w_val2[i]    = r_slot.op2.rdy ? r_slot.op2.value : w_cdb2;

    // Slot state: squash beats dispatch, dispatch only targets a slot idle at cycle start.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_slot <= '0;
      end else if (squash) begin
        r_slot.busy <= 1'b0;
      end else if (w_disp_fire && w_alloc_oh[i]) begin
        r_slot <= w_disp_slot;
      end else begin
        if (w_free_oh[i]) r_slot.busy <= 1'b0;
        if (w_wake1) begin
          r_slot.op1.rdy   <= 1'b1;
          r_slot.op1.value <= w_cdb1;
        end
        if (w_wake2) begin
          r_slot.op2.rdy   <= 1'b1;
          r_slot.op2.value <= w_cdb2;
        end
      end
    end
  end

  rs_age_select #(.ENTRIES(ENTRIES)) u_age (
    .clock       (clock),
    .reset_n     (reset_n),
    .squash      (squash),
    .i_alloc_oh  (w_alloc_oh & {ENTRIES{w_disp_fire}}),
    .i_busy      (w_busy),
    .i_free_oh   (w_free_oh),
    .i_ready     (w_ready),
    .o_grant     (w_grant),
    .o_any_ready (w_any_ready)
  );

  // One-hot grant mux; all zeros when nothing is ready.
  always_comb begin
    issue_payload   = '0;
    issue_dest_tag  = '0;
    issue_rs1_value = '0;
    issue_rs2_value = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      issue_payload   = issue_payload   | ({PAYLOAD_W{w_grant[i]}} & w_payload[i]);
      issue_dest_tag  = issue_dest_tag  | ({TAG_W{w_grant[i]}}     & w_dest[i]);
      issue_rs1_value = issue_rs1_value | ({XLEN{w_grant[i]}}      & w_val1[i]);
      issue_rs2_value = issue_rs2_value | ({XLEN{w_grant[i]}}      & w_val2[i]);
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_busy_cnt = w_busy_cnt + {{(FC_W-1){1'b0}}, w_busy[i]};
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank: one BYPASS=1 instance plus a BYPASS=0 instance for the latency contrast.
module tb_rs_bank;

  logic        clock, reset_n, squash;
  logic        disp_valid, disp_valid_b, issue_ready;
  logic [63:0] disp_payload;
  logic [4:0]  disp_dest_tag, disp_rs1_tag, disp_rs2_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_value, disp_rs2_value;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_value;

  logic        disp_ready, issue_valid, empty;
  logic [63:0] issue_payload;
  logic [4:0]  issue_dest_tag;
  logic [31:0] issue_rs1_value, issue_rs2_value;
  logic [3:0]  free_count;

  logic        disp_ready_b, issue_valid_b, empty_b;
  logic [63:0] issue_payload_b;
  logic [4:0]  issue_dest_tag_b;
  logic [31:0] issue_rs1_value_b, issue_rs2_value_b;
  logic [3:0]  free_count_b;

  int n_chk  = 0;
  int n_fail = 0;

  rs_bank #(.ENTRIES(8), .BYPASS(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
    .disp_dest_tag(disp_dest_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs1_value(disp_rs1_value), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs2_value(disp_rs2_value), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_payload(issue_payload),
    .issue_dest_tag(issue_dest_tag), .issue_rs1_value(issue_rs1_value),
    .issue_rs2_value(issue_rs2_value), .free_count(free_count), .empty(empty)
  );

  rs_bank #(.ENTRIES(8), .BYPASS(1'b0)) u_b (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .disp_valid(disp_valid_b), .disp_ready(disp_ready_b), .disp_payload(disp_payload),
    .disp_dest_tag(disp_dest_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs1_value(disp_rs1_value), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs2_value(disp_rs2_value), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid_b), .issue_ready(issue_ready), .issue_payload(issue_payload_b),
    .issue_dest_tag(issue_dest_tag_b), .issue_rs1_value(issue_rs1_value_b),
    .issue_rs2_value(issue_rs2_value_b), .free_count(free_count_b), .empty(empty_b)
  );

  always #5 clock = ~clock;

  task automatic set_idle();
    disp_valid = 1'b0; disp_valid_b = 1'b0; squash = 1'b0;
    disp_payload = 64'd0; disp_dest_tag = 5'd0;
    disp_rs1_rdy = 1'b0; disp_rs1_tag = 5'd0; disp_rs1_value = 32'd0;
    disp_rs2_rdy = 1'b0; disp_rs2_tag = 5'd0; disp_rs2_value = 32'd0;
    cdb_valid = 2'b00; cdb_tag = 10'd0; cdb_value = 64'd0;
  endtask

  task automatic drive_disp(input logic [4:0] dest, input logic r1, input logic [4:0] t1,
                            input logic [31:0] v1, input logic r2, input logic [4:0] t2,
                            input logic [31:0] v2);
    disp_valid = 1'b1; disp_dest_tag = dest;
    disp_payload = {32'hC0DE_0000, 27'd0, dest};
    disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_value = v1;
    disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_value = v2;
  endtask

  task automatic drive_cdb(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1,
                           input logic [31:0] v0, input logic [31:0] v1);
    cdb_valid = v; cdb_tag = {t1, t0}; cdb_value = {v1, v0};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_disp(5'd1, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
    disp_valid_b = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_chk++; if (free_count !== 4'd8) begin n_fail++; $display("FAIL rst_free got %0d exp 8", free_count); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", empty); end
    n_chk++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_disp_ready got %b exp 1", disp_ready); end
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue_valid got %b exp 0", issue_valid); end
    n_chk++; if (issue_dest_tag !== 5'd0) begin n_fail++; $display("FAIL rst_dest got %0d exp 0", issue_dest_tag); end
    n_chk++; if (issue_payload !== 64'd0) begin n_fail++; $display("FAIL rst_payload got %0h exp 0", issue_payload); end
    n_chk++; if (issue_valid_b !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got %b exp 0", issue_valid_b); end
    set_idle();
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock); #1;
    n_chk++; if (free_count !== 4'd8) begin n_fail++; $display("FAIL post_rst_free got %0d exp 8", free_count); end
  endtask

  task automatic test_in_order();
    logic [4:0] ed;
    issue_ready = 1'b0;
    @(negedge clock); drive_disp(5'd3, 1'b1, 5'd0, 32'h103, 1'b1, 5'd0, 32'h203);
    @(negedge clock); drive_disp(5'd4, 1'b1, 5'd0, 32'h104, 1'b1, 5'd0, 32'h204); #1;
    n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== 5'd3) begin n_fail++; $display("FAIL ord_hold1 got v%b d%0d exp v1 d3", issue_valid, issue_dest_tag); end
    @(negedge clock); drive_disp(5'd5, 1'b1, 5'd0, 32'h105, 1'b1, 5'd0, 32'h205); #1;
    n_chk++; if (issue_dest_tag !== 5'd3) begin n_fail++; $display("FAIL ord_hold2 got %0d exp 3", issue_dest_tag); end
    @(negedge clock); disp_valid = 1'b0; #1;
    n_chk++; if (issue_dest_tag !== 5'd3) begin n_fail++; $display("FAIL ord_hold3 got %0d exp 3", issue_dest_tag); end
    n_chk++; if (free_count !== 4'd5) begin n_fail++; $display("FAIL ord_free got %0d exp 5", free_count); end
    for (int k = 0; k < 3; k++) begin
      ed = 5'd3 + 5'(k);
      @(negedge clock); issue_ready = 1'b1; #1;
      n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== ed) begin n_fail++; $display("FAIL ord_issue got v%b d%0d exp v1 d%0d", issue_valid, issue_dest_tag, ed); end
      n_chk++; if (issue_rs1_value !== (32'h100 + 32'(ed)) || issue_rs2_value !== (32'h200 + 32'(ed))) begin n_fail++; $display("FAIL ord_vals got %0h/%0h exp %0h/%0h", issue_rs1_value, issue_rs2_value, 32'h100 + 32'(ed), 32'h200 + 32'(ed)); end
      n_chk++; if (issue_payload !== {32'hC0DE_0000, 27'd0, ed}) begin n_fail++; $display("FAIL ord_payload got %0h", issue_payload); end
    end
    @(negedge clock); issue_ready = 1'b0; #1;
    n_chk++; if (empty !== 1'b1 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL ord_empty got e%b v%b exp e1 v0", empty, issue_valid); end
  endtask

  task automatic test_bypass();
    issue_ready = 1'b1;
    @(negedge clock); drive_disp(5'd7, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'h10); disp_valid_b = 1'b1;
    @(negedge clock); disp_valid = 1'b0; disp_valid_b = 1'b0;
    drive_cdb(2'b10, 5'd0, 5'd9, 32'd0, 32'hAB); #1;
    n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== 5'd7) begin n_fail++; $display("FAIL byp_valid got v%b d%0d exp v1 d7", issue_valid, issue_dest_tag); end
    n_chk++; if (issue_rs1_value !== 32'hAB || issue_rs2_value !== 32'h10) begin n_fail++; $display("FAIL byp_vals got %0h/%0h exp ab/10", issue_rs1_value, issue_rs2_value); end
    n_chk++; if (issue_valid_b !== 1'b0) begin n_fail++; $display("FAIL nobyp_early got %b exp 0", issue_valid_b); end
    @(negedge clock); drive_cdb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0); #1;
    n_chk++; if (issue_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL byp_done got v%b e%b exp v0 e1", issue_valid, empty); end
    n_chk++; if (issue_valid_b !== 1'b1 || issue_dest_tag_b !== 5'd7) begin n_fail++; $display("FAIL nobyp_valid got v%b d%0d exp v1 d7", issue_valid_b, issue_dest_tag_b); end
    n_chk++; if (issue_rs1_value_b !== 32'hAB || issue_rs2_value_b !== 32'h10) begin n_fail++; $display("FAIL nobyp_vals got %0h/%0h exp ab/10", issue_rs1_value_b, issue_rs2_value_b); end
    @(negedge clock); #1;
    n_chk++; if (empty_b !== 1'b1) begin n_fail++; $display("FAIL nobyp_empty got %b exp 1", empty_b); end
  endtask

  task automatic test_dispatch_capture();
    issue_ready = 1'b1;
    @(negedge clock); drive_disp(5'd12, 1'b0, 5'd2, 32'd0, 1'b1, 5'd0, 32'h22);
    drive_cdb(2'b01, 5'd2, 5'd0, 32'h55, 32'd0); #1;
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL cap_no_bypass got %b exp 0", issue_valid); end
    @(negedge clock); set_idle(); #1;
    n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== 5'd12) begin n_fail++; $display("FAIL cap_valid got v%b d%0d exp v1 d12", issue_valid, issue_dest_tag); end
    n_chk++; if (issue_rs1_value !== 32'h55 || issue_rs2_value !== 32'h22) begin n_fail++; $display("FAIL cap_vals got %0h/%0h exp 55/22", issue_rs1_value, issue_rs2_value); end
    @(negedge clock); #1;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL cap_empty got %b exp 1", empty); end
  endtask

  task automatic test_age_order();
    issue_ready = 1'b1;
    @(negedge clock); drive_disp(5'd1, 1'b0, 5'd10, 32'd0, 1'b1, 5'd0, 32'h1);
    @(negedge clock); drive_disp(5'd2, 1'b0, 5'd11, 32'd0, 1'b1, 5'd0, 32'h2);
    @(negedge clock); disp_valid = 1'b0; drive_cdb(2'b01, 5'd10, 5'd0, 32'h1, 32'd0); #1;
    n_chk++; if (issue_dest_tag !== 5'd1) begin n_fail++; $display("FAIL age_first got %0d exp 1", issue_dest_tag); end
    @(negedge clock); drive_cdb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    drive_disp(5'd3, 1'b1, 5'd0, 32'h3, 1'b1, 5'd0, 32'h3); #1;
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL age_gap got %b exp 0", issue_valid); end
    @(negedge clock); disp_valid = 1'b0; issue_ready = 1'b0; #1;
    n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== 5'd3) begin n_fail++; $display("FAIL age_young got v%b d%0d exp v1 d3", issue_valid, issue_dest_tag); end
    @(negedge clock); drive_cdb(2'b10, 5'd0, 5'd11, 32'd0, 32'h2E); #1;
    n_chk++; if (issue_dest_tag !== 5'd2 || issue_rs1_value !== 32'h2E) begin n_fail++; $display("FAIL age_older_wins got d%0d v%0h exp d2 v2e", issue_dest_tag, issue_rs1_value); end
    @(negedge clock); drive_cdb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0); issue_ready = 1'b1; #1;
    n_chk++; if (issue_dest_tag !== 5'd2 || issue_rs1_value !== 32'h2E) begin n_fail++; $display("FAIL age_latched got d%0d v%0h exp d2 v2e", issue_dest_tag, issue_rs1_value); end
    @(negedge clock); #1;
    n_chk++; if (issue_dest_tag !== 5'd3) begin n_fail++; $display("FAIL age_last got %0d exp 3", issue_dest_tag); end
    @(negedge clock); #1;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL age_empty got %b exp 1", empty); end
  endtask

  task automatic test_full();
    issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock); drive_disp(5'd16 + 5'(k), 1'b0, 5'(k), 32'd0, 1'b1, 5'd0, 32'h60 + 32'(k));
    end
    @(negedge clock); drive_disp(5'd30, 1'b1, 5'd0, 32'h1E, 1'b1, 5'd0, 32'h1E); #1;
    n_chk++; if (disp_ready !== 1'b0 || free_count !== 4'd0) begin n_fail++; $display("FAIL full_flags got r%b f%0d exp r0 f0", disp_ready, free_count); end
    @(negedge clock); disp_valid = 1'b0; #1;
    n_chk++; if (free_count !== 4'd0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop got f%0d v%b exp f0 v0", free_count, issue_valid); end
    @(negedge clock); drive_cdb(2'b01, 5'd5, 5'd0, 32'h77, 32'd0); #1;
    n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== 5'd21) begin n_fail++; $display("FAIL full_issue got v%b d%0d exp v1 d21", issue_valid, issue_dest_tag); end
    n_chk++; if (issue_rs1_value !== 32'h77 || issue_rs2_value !== 32'h65) begin n_fail++; $display("FAIL full_vals got %0h/%0h exp 77/65", issue_rs1_value, issue_rs2_value); end
    @(negedge clock); drive_cdb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0); #1;
    n_chk++; if (free_count !== 4'd1 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed got f%0d r%b exp f1 r1", free_count, disp_ready); end
    @(negedge clock); drive_disp(5'd25, 1'b1, 5'd0, 32'h19, 1'b1, 5'd0, 32'h19);
    @(negedge clock); disp_valid = 1'b0; issue_ready = 1'b0; #1;
    n_chk++; if (u_dut.g_slot[5].r_slot.busy !== 1'b1 || u_dut.g_slot[5].r_slot.dest_tag !== 5'd25) begin n_fail++; $display("FAIL full_reuse_slot5 got b%b d%0d exp b1 d25", u_dut.g_slot[5].r_slot.busy, u_dut.g_slot[5].r_slot.dest_tag); end
    n_chk++; if (free_count !== 4'd0 || issue_dest_tag !== 5'd25) begin n_fail++; $display("FAIL full_refill got f%0d d%0d exp f0 d25", free_count, issue_dest_tag); end
  endtask

  task automatic test_squash();
    issue_ready = 1'b0;
    @(negedge clock); squash = 1'b1;
    @(negedge clock); squash = 1'b0; #1;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sq_clear got %b exp 1", empty); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); drive_disp(5'd20 + 5'(k), 1'b0, 5'd31, 32'd0, 1'b0, 5'd31, 32'd0);
    end
    @(negedge clock); drive_disp(5'd28, 1'b1, 5'd0, 32'h1C, 1'b1, 5'd0, 32'h1C); squash = 1'b1; #1;
    n_chk++; if (free_count !== 4'd4) begin n_fail++; $display("FAIL sq_pre got %0d exp 4", free_count); end
    @(negedge clock); squash = 1'b0; disp_valid = 1'b0; #1;
    n_chk++; if (empty !== 1'b1 || free_count !== 4'd8 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL sq_post got e%b f%0d v%b exp e1 f8 v0", empty, free_count, issue_valid); end
    @(negedge clock); drive_disp(5'd9, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0, 32'h9);
    @(negedge clock); disp_valid = 1'b0; #1;
    n_chk++; if (issue_valid !== 1'b1 || issue_dest_tag !== 5'd9) begin n_fail++; $display("FAIL arst_pre got v%b d%0d exp v1 d9", issue_valid, issue_dest_tag); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (issue_valid !== 1'b0 || issue_dest_tag !== 5'd0 || free_count !== 4'd8) begin n_fail++; $display("FAIL arst_async got v%b d%0d f%0d exp v0 d0 f8", issue_valid, issue_dest_tag, free_count); end
    @(negedge clock); reset_n = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    reset_n = 1'b0;
    issue_ready = 1'b0;
    set_idle();
    test_reset();
    test_in_order();
    test_bypass();
    test_dispatch_capture();
    test_age_order();
    test_full();
    test_squash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
